// File: rtl/music_state_seq.sv
// music_state_seq: turns 1-cycle game events into the registered 2-bit music state with beat-timed jingles
// Ports: clk, rst_n (async active-low); start/win/lose/stop event pulses in;
//        state (00 idle, 01 game, 10 win, 11 lose), beat strobe, jingle_done pulse out.
// Define MUSIC_JINGLE_HOLD_EN to hold WIN/LOSE indefinitely (no timeout; start returns to GAME).
module music_state_seq #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int BEAT_HZ      = 4,
   parameter int JINGLE_BEATS = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       win,
   input  logic       lose,
   input  logic       stop,
   output logic [1:0] state,
   output logic       beat,
   output logic       jingle_done
);
   localparam int DIV = CLK_HZ / BEAT_HZ;
   localparam int DW  = $clog2(DIV);
   localparam int BW  = $clog2(JINGLE_BEATS + 1);
   typedef enum logic [1:0] {IDLE = 2'b00, GAME = 2'b01, WIN = 2'b10, LOSE = 2'b11} state_t;
   state_t          state_q, state_d;
   logic [DW-1:0]   div_q, div_d;
   logic [BW-1:0]   cnt_q, cnt_d, cnt_inc;
   logic            beat_q, beat_d, done_q, done_d, tick, clear;
   assign tick    = (state_q != IDLE) && (div_q == DW'(DIV - 1));
   assign cnt_inc = cnt_q + BW'(1);
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         if (start) state_d = GAME;
      end else if (stop) begin
         state_d = IDLE;
      end else if (state_q == GAME) begin
         if (lose)     state_d = LOSE;
         else if (win) state_d = WIN;
`ifdef MUSIC_JINGLE_HOLD_EN
      end else if (start) begin
         state_d = GAME;
`else
      end else if (tick && cnt_inc == BW'(JINGLE_BEATS)) begin
         state_d = IDLE;
         done_d  = 1'b1;
`endif
      end
      // the timeout edge still emits the final jingle beat; any other move to IDLE suppresses it
      beat_d = tick && (state_d != IDLE || done_d);
      // every state change realigns beat phase to the entry edge
      clear  = (state_d != state_q) || (state_d == IDLE);
      div_d  = (clear || tick) ? '0 : div_q + DW'(1);
      cnt_d  = clear ? '0 : (tick && state_q[1] && cnt_q != BW'(JINGLE_BEATS)) ? cnt_inc : cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         beat_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         beat_q  <= beat_d;
         done_q  <= done_d;
      end
   end
   assign state       = state_q;
   assign beat        = beat_q;
   assign jingle_done = done_q;
endmodule

// File: tb/tb_music_state_seq.sv
// tb_music_state_seq: table-driven and directed checks of music_state_seq with DIV=10, JINGLE_BEATS=3
module tb_music_state_seq;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, win = 1'b0, lose = 1'b0, stop = 1'b0;
   logic [1:0] state;
   logic       beat, jingle_done;
   int         checks = 0, failures = 0;

   music_state_seq #(.CLK_HZ(40), .BEAT_HZ(4), .JINGLE_BEATS(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .win(win), .lose(lose), .stop(stop),
      .state(state), .beat(beat), .jingle_done(jingle_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       s, w, l, p;
      int         n;
      logic [1:0] st;
      logic       bt, dn;
      int         nb;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // drive events for one edge, then sample 1 ns after that edge
   task automatic step(input logic s, input logic w, input logic l, input logic p);
      start = s; win = w; lose = l; stop = p;
      @(posedge clk);
      #1;
      start = 1'b0; win = 1'b0; lose = 1'b0; stop = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   task automatic check_out(input string name, input logic [1:0] st, input logic bt, input logic dn);
      chk({name, "_state"}, 32'(state), 32'(st));
      chk({name, "_beat"}, 32'(beat), 32'(bt));
      chk({name, "_done"}, 32'(jingle_done), 32'(dn));
   endtask

   initial begin
      vec_t tbl[$];
      int   nb, nd;
      #2;
      check_out("reset", 2'b00, 1'b0, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      #3;
`ifndef MUSIC_JINGLE_HOLD_EN
      //           s  w  l  p   n  state  bt dn nb
      tbl.push_back('{0, 0, 0, 0,  4, 2'b00, 0, 0, 0});
      tbl.push_back('{0, 1, 0, 0,  1, 2'b00, 0, 0, 0});
      tbl.push_back('{1, 0, 0, 0,  1, 2'b01, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0,  9, 2'b01, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0,  1, 2'b01, 1, 0, 1});
      tbl.push_back('{0, 0, 0, 0, 10, 2'b01, 1, 0, 1});
      tbl.push_back('{1, 0, 0, 0, 10, 2'b01, 1, 0, 1});
      tbl.push_back('{0, 1, 1, 0,  1, 2'b11, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0,  9, 2'b11, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0,  1, 2'b11, 1, 0, 1});
      tbl.push_back('{0, 0, 0, 0, 10, 2'b11, 1, 0, 1});
      tbl.push_back('{0, 0, 0, 0, 10, 2'b00, 1, 1, 1});
      tbl.push_back('{0, 0, 0, 0,  1, 2'b00, 0, 0, 0});
      tbl.push_back('{1, 0, 0, 0,  1, 2'b01, 0, 0, 0});
      tbl.push_back('{1, 0, 0, 1,  1, 2'b00, 0, 0, 0});
      tbl.push_back('{1, 0, 0, 0,  1, 2'b01, 0, 0, 0});
      tbl.push_back('{0, 1, 0, 0,  1, 2'b10, 0, 0, 0});
      tbl.push_back('{1, 1, 1, 0,  5, 2'b10, 0, 0, 0});
      tbl.push_back('{0, 0, 0, 0, 25, 2'b00, 1, 1, 3});
      tbl.push_back('{0, 0, 1, 0,  2, 2'b00, 0, 0, 0});
      foreach (tbl[k]) begin
         nb = 0;
         step(tbl[k].s, tbl[k].w, tbl[k].l, tbl[k].p);
         nb += int'(beat);
         for (int i = 1; i < tbl[k].n; i++) begin
            step(0, 0, 0, 0);
            nb += int'(beat);
         end
         check_out($sformatf("vec%0d", k), tbl[k].st, tbl[k].bt, tbl[k].dn);
         chk($sformatf("vec%0d_beats", k), 32'(nb), 32'(tbl[k].nb));
      end
`else
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      nb = 0; nd = 0;
      for (int i = 0; i < 500; i++) begin
         step(0, 0, 0, 0);
         nb += int'(beat);
         nd += int'(jingle_done);
      end
      chk("hold_beats", 32'(nb), 32'd50);
      chk("hold_done", 32'(nd), 32'd0);
      check_out("hold_win", 2'b10, 1'b1, 1'b0);
      step(1, 0, 0, 0);
      check_out("hold_start", 2'b01, 1'b0, 1'b0);
      idle(9);
      check_out("hold_pre", 2'b01, 1'b0, 1'b0);
      idle(1);
      check_out("hold_beat", 2'b01, 1'b1, 1'b0);
      step(0, 0, 0, 1);
      check_out("hold_stop", 2'b00, 1'b0, 1'b0);
`endif
      // stop on the edge of the final lose beat
      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      idle(29);
      check_out("lose_pre", 2'b11, 1'b0, 1'b0);
      step(0, 0, 0, 1);
      check_out("lose_stop", 2'b00, 1'b0, 1'b0);
      idle(1);
      check_out("lose_after", 2'b00, 1'b0, 1'b0);
      // asynchronous reset mid-jingle
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      idle(19);
      check_out("win_pre", 2'b10, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_out("rst_async", 2'b00, 1'b0, 1'b0);
      idle(3);
      check_out("rst_hold", 2'b00, 1'b0, 1'b0);
      rst_n = 1'b1;
      nb = 0; nd = 0;
      for (int i = 0; i < 40; i++) begin
         step(0, 0, 0, 0);
         nb += int'(beat) + (state != 2'b00 ? 1 : 0);
         nd += int'(jingle_done);
      end
      chk("post_rst_activity", 32'(nb), 32'd0);
      chk("post_rst_done", 32'(nd), 32'd0);
      step(1, 0, 0, 0);
      check_out("post_rst_start", 2'b01, 1'b0, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/music_state_seq.md
# music_state_seq

Sequencer that produces the 2-bit music state consumed by the speaker's one-hot increase decoder (00 idle, 01 game, 10 win, 11 lose). It turns single-cycle game events into a registered state, times the win/lose jingles in beats, and emits a beat strobe for the note-index counters. It sits between the game-logic top level and the speaker path.

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- BEAT_HZ, 4, beat rate; DIV = CLK_HZ/BEAT_HZ cycles per beat, DIV >= 2
- JINGLE_BEATS, 16, win/lose jingle length in beats, >= 1

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse, begin game music
- win  in  1  1-cycle pulse, player won
- lose  in  1  1-cycle pulse, player lost
- stop  in  1  1-cycle pulse, abort to idle
- state  out  2  music state: 00 IDLE, 01 GAME, 10 WIN, 11 LOSE
- beat  out  1  1-cycle strobe, one per beat, only while state != IDLE
- jingle_done  out  1  1-cycle pulse when a jingle times out

## Operation
- Reset: state=00, beat=0, jingle_done=0, divider=0, beat count=0.
- Event priority on the same cycle: stop > lose > win > start; only the winning event acts.
- IDLE: start -> GAME; win/lose/stop ignored.
- GAME: win -> WIN; lose -> LOSE; stop -> IDLE; start ignored (no restart).
- WIN/LOSE: count beats; after JINGLE_BEATS beats -> IDLE with jingle_done. stop -> IDLE, no jingle_done. start/win/lose ignored.
- Divider: counts 0..DIV-1 while state != IDLE; wraps to 0 and raises beat when it reaches DIV-1. Divider and beat count clear to 0 on every state change, so beat phase aligns to state entry. Held at 0 in IDLE.
- Divider width $clog2(DIV); beat count width $clog2(JINGLE_BEATS+1); no overflow possible.
- Beat count increments on each beat in WIN/LOSE; when the incremented value equals JINGLE_BEATS, the transition happens on that same edge.

## Timing
- All outputs registered. Event sampled at edge N -> state updated after edge N (1-cycle latency).
- First beat after entering a non-IDLE state: high in the DIV-th cycle after the entry edge; then every DIV cycles.
- Jingle timeout: the edge that would produce the JINGLE_BEATS-th beat sets state=00 and jingle_done=1 for one cycle; beat is also 1 on that cycle (last beat of the jingle).
- stop coinciding with the final beat: stop wins; state=00, jingle_done=0, beat=0.
- Reset asserted mid-jingle: all outputs go to reset values immediately (asynchronous); no jingle_done.
- Event inputs are synchronous to clk; no internal synchronizers.

## Configuration
- MUSIC_JINGLE_HOLD_EN defined: WIN/LOSE never time out; beats keep coming with the beat count saturating; jingle_done is tied 0; start in WIN/LOSE -> GAME (divider cleared); stop -> IDLE.
- Undefined: timeout behaviour as in Operation; start in WIN/LOSE ignored.

## Test plan
All with CLK_HZ=40, BEAT_HZ=4 (DIV=10), JINGLE_BEATS=3, macro undefined unless stated.
- Reset, then start pulse at edge 5 -> state=01 after edge 5; beat high in cycles 15, 25, 35...; state stays 01.
- GAME, win pulse -> state=10; beats at +10,+20; at +30 state=00, jingle_done=1 and beat=1 for exactly one cycle.
- GAME, win and lose in the same cycle -> state=11; start+stop same cycle in GAME -> state=00.
- LOSE, stop on the cycle of the 3rd beat -> state=00, jingle_done=0, beat=0.
- WIN, rst_n low mid-jingle for 3 cycles -> state=00, beat=0, jingle_done=0 immediately; no activity until a new start.
- MUSIC_JINGLE_HOLD_EN defined: WIN held for 50 beats with no jingle_done; start -> state=01, next beat 10 cycles later.
